seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
- Upstream driver for the 4-digit 7-segment pin remapper.
- Holds a 16-bit hex value plus per-digit decimal points and time-multiplexes the four digits.
- Produces the 12-bit logical word [SEL1,SEL2,SEL3,SEL4,A,B,C,D,E,F,G,DP] (bit 11 = SEL1, bit 0 = DP) that the remapper converts to board pin order.
- Adds tear-free value update, leading-zero blanking and anti-ghosting dead time.

Parameters:
REFRESH_DIV, 12000, clk cycles per digit slot (>= 4)
DEAD_CYC, 16, cycles at start of each slot with all selects inactive (< REFRESH_DIV)
SEL_ACTIVE_LOW, 1, 1 = digit selects driven low when active
SEG_ACTIVE_LOW, 1, 1 = segments/DP driven low when lit
BLANK_LEADING, 1, 1 = suppress leading zeros

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = scanning; 0 = display dark
load  input  1  single-cycle request to capture value/dp_in
value  input  16  hex digits; [15:12] = digit 1 (leftmost) .. [3:0] = digit 4
dp_in  input  4  decimal points; [3] = digit 1 .. [0] = digit 4
seg_word  output  12  registered logical word [SEL1..SEL4,A..G,DP]
frame_tick  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async assert, sync release):
  - prescaler=0, digit index=0, active/pending value and dp=0, pending flag=0.
  - frame_tick=0.
  - seg_word = all inactive: 12'hFFF with default parameters.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. On wrap, digit index advances 0->1->2->3->0.
- Frame boundary = the cycle the index wraps 3->0. In that cycle:
  - frame_tick=1.
  - If the pending flag is set: active <= pending, flag cleared.
- load:
  - Captures value/dp_in into pending and sets the flag.
  - A later load before the boundary overwrites pending (last wins).
  - Load in the same cycle as a boundary: the boundary transfers the pre-existing pending contents; the new load lands in pending with the flag set (shown next frame).
  - The displayed value never changes mid-frame.
- Segment decode (A..G, 1 = lit), hex 0..F:
  - 0:1111110  1:0110000  2:1101101  3:1111001
  - 4:0110011  5:1011011  6:1011111  7:1110000
  - 8:1111111  9:1111011  A:1110111  b:0011111
  - C:1001110  d:0111101  E:1001111  F:1000111
- Blanking (BLANK_LEADING=1):
  - Digit k (1..3) is blanked when its nibble is 0, its DP is 0, and every more-significant digit is blanked.
  - Digit 4 is never blanked.
  - A blanked digit lights no segments and no DP.
- Select: one-hot for the current index. All selects are inactive while prescaler < DEAD_CYC; segment bits stay valid during dead time.
- Polarity: logical active-high word, XOR-inverted per SEL_ACTIVE_LOW / SEG_ACTIVE_LOW.
- Latency: seg_word is registered, one cycle after the prescaler/index state it reflects.
- enable=0:
  - Prescaler and index are held at 0; seg_word is all inactive; frame_tick=0.
  - Pending loads are still accepted.
  - Scanning restarts at digit 1, slot start, on the cycle enable rises.
- rst_n asserted mid-scan: immediate return to reset values; pending data is lost.

Test Plan:
Bench uses REFRESH_DIV=8, DEAD_CYC=2, other parameters default.
1. Reset and first value:
   - During reset: seg_word=12'hFFF.
   - After release, enable=1, load 16'h1234, dp_in=0.
   - After the next frame_tick, digit-1 slot past dead time: seg_word=12'h79F.
   - Digit-1 slot during dead cycles: 12'hF9F.
2. Leading-zero blanking: load 16'h0005, dp_in=0.
   - Digit-1 slot: 12'h7FF.
   - Digit-4 slot: 12'hE49.
3. DP stops blanking: load 16'h0005, dp_in=4'b0010.
   - Digit-3 slot: 12'hD02.
   - Digit-2 slot: 12'hBFF.
4. Tear-free update:
   - Load 16'hAAAA mid-frame, then 16'hBBBB; no change before frame_tick.
   - Next frame shows all digits 'b': 12'h7C1 in digit-1 slot.
   - Load asserted exactly on frame_tick: shown one frame later.
5. Enable and reset mid-scan:
   - Deassert enable in the digit-3 slot: seg_word=12'hFFF next cycle.
   - Re-enable: digit-1 slot restarts with 2 dead cycles.
   - Pulse rst_n low mid-slot: seg_word=12'hFFF asynchronously and the display stays blank until a new load plus frame_tick.

Source files
------------

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: 4-digit 7-segment scanner with frame-aligned value update,
// leading-zero blanking and dead time between digit slots.
module seg_scan_mux #(
  parameter int REFRESH_DIV = 12000,
  parameter int DEAD_CYC = 16,
  parameter bit SEL_ACTIVE_LOW = 1,
  parameter bit SEG_ACTIVE_LOW = 1,
  parameter bit BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [11:0] seg_word,
  output logic        frame_tick
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [11:0] POL = {{4{SEL_ACTIVE_LOW}}, {8{SEG_ACTIVE_LOW}}};
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   act_val, pend_val;
  logic [3:0]    act_dp, pend_dp;
  logic          pend_flag;
  logic          wrap, boundary, dp_bit;
  logic [3:0]    nib, blank, sel;
  logic [6:0]    segs;
  logic [11:0]   word;
  assign wrap = presc == PW'(REFRESH_DIV - 1);
  assign boundary = enable && wrap && idx == 2'd3;
  // digit 1 (idx 0) lives in the top nibble, so index the value by ~idx
  assign nib = 4'(act_val >> {~idx, 2'b00});
  assign dp_bit = act_dp[~idx];
  assign blank[3] = BLANK_LEADING && act_val[15:12] == 4'h0 && !act_dp[3];
  assign blank[2] = blank[3] && act_val[11:8] == 4'h0 && !act_dp[2];
  assign blank[1] = blank[2] && act_val[7:4] == 4'h0 && !act_dp[1];
  assign blank[0] = 1'b0;
  always_comb begin
    case (nib)
      4'h0: segs = 7'b1111110;
      4'h1: segs = 7'b0110000;
      4'h2: segs = 7'b1101101;
      4'h3: segs = 7'b1111001;
      4'h4: segs = 7'b0110011;
      4'h5: segs = 7'b1011011;
      4'h6: segs = 7'b1011111;
      4'h7: segs = 7'b1110000;
      4'h8: segs = 7'b1111111;
      4'h9: segs = 7'b1111011;
      4'hA: segs = 7'b1110111;
      4'hB: segs = 7'b0011111;
      4'hC: segs = 7'b1001110;
      4'hD: segs = 7'b0111101;
      4'hE: segs = 7'b1001111;
      default: segs = 7'b1000111;
    endcase
  end
  assign sel = presc < PW'(DEAD_CYC) ? 4'b0000 : 4'b1000 >> idx;
  assign word = {sel, blank[~idx] ? 8'h00 : {segs, dp_bit}} ^ POL;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx <= 2'd0;
      act_val <= 16'h0;
      act_dp <= 4'h0;
      pend_val <= 16'h0;
      pend_dp <= 4'h0;
      pend_flag <= 1'b0;
      frame_tick <= 1'b0;
      seg_word <= POL;
    end else begin
      presc <= (!enable || wrap) ? '0 : presc + PW'(1);
      idx <= !enable ? 2'd0 : wrap ? idx + 2'd1 : idx;
      frame_tick <= boundary;
      seg_word <= enable ? word : POL;
      if (boundary && pend_flag) begin
        act_val <= pend_val;
        act_dp <= pend_dp;
      end
      // a load on the boundary cycle wins the flag so it shows next frame
      if (load) begin
        pend_val <= value;
        pend_dp <= dp_in;
        pend_flag <= 1'b1;
      end else if (boundary) begin
        pend_flag <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed stimulus with a cycle-stamped expectation queue
// drained by an independent monitor on the falling clock edge.
module tb_seg_scan_mux;
  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [11:0] seg_word;
  logic        frame_tick;
  typedef struct {
    int          cyc;
    logic [11:0] word;
    string       name;
  } exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  seg_scan_mux #(.REFRESH_DIV(8), .DEAD_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .value(value), .dp_in(dp_in), .seg_word(seg_word), .frame_tick(frame_tick)
  );
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: missed sample at cycle %0d, now %0d", e.name, e.cyc, cyc);
      end else chk(e.name, seg_word, e.word);
    end
  end
  task automatic push(input int off, input logic [11:0] w, input string n);
    q.push_back('{cyc + off, w, n});
  endtask
  task automatic expect_frame(input logic [11:0] w0, w1, w2, w3, input string n);
    push(5, w0, {n, "_d1"});
    push(13, w1, {n, "_d2"});
    push(21, w2, {n, "_d3"});
    push(29, w3, {n, "_d4"});
  endtask
  task automatic wait_tick();
    int n = 0;
    @(negedge clk);
    while (!frame_tick && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!frame_tick) begin
      checks++;
      errors++;
      $display("FAIL wait_tick: got no frame_tick, required one within 100 cycles");
    end
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d unchecked entries, required 0", q.size());
      q.delete();
    end
  endtask
  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1;
    value = v;
    dp_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_word", seg_word, 12'hFFF);
    chk("reset_tick", {11'd0, frame_tick}, 12'h000);
    rst_n = 1'b1;
    enable = 1'b1;
    // 1: first value, dead cycles and slot edges
    wait_tick();
    pulse_load(16'h1234, 4'h0);
    wait_tick();
    push(1, 12'hF9F, "t1_dead0");
    push(2, 12'hF9F, "t1_dead1");
    push(3, 12'h79F, "t1_live_first");
    push(8, 12'h79F, "t1_live_last");
    push(9, 12'hF25, "t1_d2_dead");
    push(13, 12'hB25, "t1_d2");
    push(21, 12'hD0D, "t1_d3");
    push(29, 12'hE99, "t1_d4");
    drain();
    // 2: leading-zero blanking
    wait_tick();
    pulse_load(16'h0005, 4'h0);
    wait_tick();
    expect_frame(12'h7FF, 12'hBFF, 12'hDFF, 12'hE49, "t2");
    drain();
    // 3: a decimal point stops blanking
    wait_tick();
    pulse_load(16'h0005, 4'b0010);
    wait_tick();
    expect_frame(12'h7FF, 12'hBFF, 12'hD02, 12'hE49, "t3");
    drain();
    // 4: tear-free update
    wait_tick();
    expect_frame(12'h7FF, 12'hBFF, 12'hD02, 12'hE49, "t4_hold");
    repeat (9) @(negedge clk);
    pulse_load(16'hAAAA, 4'h0);
    repeat (9) @(negedge clk);
    pulse_load(16'hBBBB, 4'h0);
    wait_tick();
    expect_frame(12'h7C1, 12'hBC1, 12'hDC1, 12'hEC1, "t4_b");
    pulse_load(16'h1234, 4'h0);
    wait_tick();
    expect_frame(12'h79F, 12'hB25, 12'hD0D, 12'hE99, "t4_late");
    repeat (10) @(negedge clk);
    pulse_load(16'hBBBB, 4'h0);
    repeat (20) @(negedge clk);
    pulse_load(16'h0005, 4'h0);
    chk("t4_tick_on_load", {11'd0, frame_tick}, 12'h001);
    expect_frame(12'h7C1, 12'hBC1, 12'hDC1, 12'hEC1, "t4_pre");
    wait_tick();
    expect_frame(12'h7FF, 12'hBFF, 12'hDFF, 12'hE49, "t4_next");
    drain();
    // 5: enable drop/restart, then async reset discards pending data
    wait_tick();
    pulse_load(16'h1234, 4'h0);
    wait_tick();
    repeat (21) @(negedge clk);
    enable = 1'b0;
    push(1, 12'hFFF, "t5_off");
    push(4, 12'hFFF, "t5_off_hold");
    repeat (8) @(negedge clk);
    chk("t5_no_tick", {11'd0, frame_tick}, 12'h000);
    enable = 1'b1;
    push(1, 12'hF9F, "t5_re_dead0");
    push(2, 12'hF9F, "t5_re_dead1");
    push(3, 12'h79F, "t5_re_live");
    repeat (5) @(negedge clk);
    pulse_load(16'hBBBB, 4'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_reset", seg_word, 12'hFFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_tick();
    push(5, 12'h7FF, "t5_blank_d1");
    push(13, 12'hBFF, "t5_blank_d2");
    push(21, 12'hDFF, "t5_blank_d3");
    wait_tick();
    push(5, 12'h7FF, "t5_still_blank");
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
